pbus_arb: RTL and testbench

PBUS_ARB -- requirements
Module: pbus_arb

---
 rtl/pbus_arb.sv | 114 +++++++++++
 tb/tb_pbus_arb.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pbus_arb.sv
// pbus_arb: two-master round-robin arbiter onto a single peripheral bus connector,
// one transaction in flight, with a wait-cycle timeout that aborts with a fault.
module pbus_arb #(
  parameter int TIMEOUT     = 255,
  parameter int XLEN        = 32,
  parameter int BUS_WIDTH   = 32,
  parameter int BUS_ACC_CNT = 4,
  localparam int AW = $clog2(BUS_ACC_CNT),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic [XLEN-1:0]      m0_addr,
  input  logic                 m0_w_rb,
  input  logic [AW-1:0]        m0_acc,
  input  logic [BUS_WIDTH-1:0] m0_wdata,
  output logic                 m0_resp,
  output logic [BUS_WIDTH-1:0] m0_rdata,
  output logic                 m0_fault,
  input  logic                 m1_req,
  input  logic [XLEN-1:0]      m1_addr,
  input  logic                 m1_w_rb,
  input  logic [AW-1:0]        m1_acc,
  input  logic [BUS_WIDTH-1:0] m1_wdata,
  output logic                 m1_resp,
  output logic [BUS_WIDTH-1:0] m1_rdata,
  output logic                 m1_fault,
  output logic                 s_req,
  output logic [XLEN-1:0]      s_addr,
  output logic                 s_w_rb,
  output logic [AW-1:0]        s_acc,
  output logic [BUS_WIDTH-1:0] s_wdata,
  input  logic                 s_resp,
  input  logic [BUS_WIDTH-1:0] s_rdata,
  input  logic                 s_fault,
  input  logic                 s_bus_fault,
  output logic                 tmo,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t               state;
  logic                 last;
  logic                 gnt;
  logic [CW-1:0]        cnt;
  logic [BUS_WIDTH-1:0] cap_rdata;
  logic                 win;
  logic                 in_issue;
  logic                 in_wait;
  logic                 hit;
  logic                 expire;
  logic                 flt;
  assign in_issue = state == ISSUE;
  assign in_wait  = state == WAIT;
  assign win      = (m0_req & m1_req) ? ~last : m1_req;
  // a decode miss only counts while the request is actually on the bus
  assign hit      = (in_issue | in_wait) & (s_resp | s_fault | (in_issue & s_bus_fault));
  assign expire   = in_wait & ~hit & (cnt == CW'(TIMEOUT - 1));
  assign flt      = expire | s_fault | (in_issue & s_bus_fault);
  assign s_req    = in_issue;
  assign busy     = state != IDLE;
  assign m0_rdata = cap_rdata;
  assign m1_rdata = cap_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt       <= 1'b0;
      cnt       <= '0;
      s_addr    <= '0;
      s_w_rb    <= 1'b0;
      s_acc     <= '0;
      s_wdata   <= '0;
      cap_rdata <= '0;
      m0_resp   <= 1'b0;
      m1_resp   <= 1'b0;
      m0_fault  <= 1'b0;
      m1_fault  <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      m0_resp  <= 1'b0;
      m1_resp  <= 1'b0;
      m0_fault <= 1'b0;
      m1_fault <= 1'b0;
      tmo      <= 1'b0;
      case (state)
        IDLE: if (m0_req | m1_req) begin
          gnt     <= win;
          last    <= win;
          s_addr  <= win ? m1_addr : m0_addr;
          s_w_rb  <= win ? m1_w_rb : m0_w_rb;
          s_acc   <= win ? m1_acc : m0_acc;
          s_wdata <= win ? m1_wdata : m0_wdata;
          state   <= ISSUE;
        end
        ISSUE: if (!hit) begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT:    cnt   <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
      if (hit | expire) begin
        state     <= DONE;
        cap_rdata <= expire ? '0 : s_rdata;
        m0_resp   <= ~gnt;
        m1_resp   <= gnt;
        m0_fault  <= ~gnt & flt;
        m1_fault  <= gnt & flt;
        tmo       <= expire;
      end
    end
  end
endmodule

// File: tb/tb_pbus_arb.sv
// tb_pbus_arb: directed and randomized transactions checked against a
// transaction-level model of grant order, latency, fault and timeout rules.
module tb_pbus_arb;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_w_rb, m0_resp, m0_fault;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_acc;
  logic        m1_req, m1_w_rb, m1_resp, m1_fault;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_acc;
  logic        s_req, s_w_rb, s_resp, s_fault, s_bus_fault, tmo, busy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_acc;
  int          checks = 0;
  int          errors = 0;
  bit          last_g;

  pbus_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc),
    .m0_wdata(m0_wdata), .m0_resp(m0_resp), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc),
    .m1_wdata(m1_wdata), .m1_resp(m1_resp), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
    .s_req(s_req), .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata),
    .s_resp(s_resp), .s_rdata(s_rdata), .s_fault(s_fault), .s_bus_fault(s_bus_fault),
    .tmo(tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 ok response, 1 slave fault, 2 decode miss, 3 silent slave; d = cycles after s_req
  task automatic txn(input bit r0, input bit r1, input int d, input int kind, input bit rnd);
    bit          w, ok;
    int          e;
    logic [31:0] rd, ea, ewd;
    logic        ew;
    logic [1:0]  eacc;
    if (rnd && r0 && !m0_req) begin
      m0_addr = $urandom; m0_w_rb = 1'($urandom); m0_acc = 2'($urandom); m0_wdata = $urandom;
    end
    if (rnd && r1 && !m1_req) begin
      m1_addr = $urandom; m1_w_rb = 1'($urandom); m1_acc = 2'($urandom); m1_wdata = $urandom;
    end
    m0_req = m0_req | r0;
    m1_req = m1_req | r1;
    w      = (m0_req && m1_req) ? !last_g : m1_req;
    last_g = w;
    ea     = w ? m1_addr : m0_addr;
    ew     = w ? m1_w_rb : m0_w_rb;
    eacc   = w ? m1_acc : m0_acc;
    ewd    = w ? m1_wdata : m0_wdata;
    rd     = $urandom;
    ok     = kind != 3 && (d == 0 || (kind != 2 && d <= TO));
    e      = ok ? 2 + d : 2 + TO;
    chk("idle_busy", busy, 0);
    for (int c = 1; c <= e; c++) begin
      step();
      s_resp      = (c - 1 == d) && kind == 0;
      s_fault     = (c - 1 == d) && kind == 1;
      s_bus_fault = (c - 1 == d) && kind == 2;
      s_rdata     = (c - 1 == d) ? rd : $urandom;
      chk("busy", busy, 1);
      if (c == 1) begin
        chk("s_addr", s_addr, ea);
        chk("s_w_rb", s_w_rb, ew);
        chk("s_acc", s_acc, eacc);
        chk("s_wdata", s_wdata, ewd);
      end
      if (c < e) begin
        chk("s_req", s_req, c == 1);
        chk("early_resp", {m0_resp, m1_resp, tmo}, 0);
      end else begin
        chk("s_req_done", s_req, 0);
        chk("resp", {m0_resp, m1_resp}, {!w, w});
        chk("fault", {m0_fault, m1_fault}, {!w && (kind != 0 || !ok), w && (kind != 0 || !ok)});
        chk("rdata", w ? m1_rdata : m0_rdata, ok ? rd : 0);
        chk("tmo", tmo, !ok);
      end
    end
    step();
    {s_resp, s_fault, s_bus_fault} = 3'b000;
    if (w) m1_req = 1'b0; else m0_req = 1'b0;
    chk("post_resp", {m0_resp, m1_resp, tmo, busy}, 0);
  endtask

  initial begin
    {m0_req, m1_req, m0_w_rb, m1_w_rb} = 4'b0;
    {m0_addr, m1_addr, m0_wdata, m1_wdata} = '0;
    {m0_acc, m1_acc} = 4'b0;
    {s_resp, s_fault, s_bus_fault} = 3'b000;
    s_rdata = '0;
    rst = 1'b1;
    step();
    step();
    chk("rst_out", {s_req, m0_resp, m1_resp, m0_fault, m1_fault, tmo, busy}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    chk("rst_addr", s_addr, 0);
    rst = 1'b0;
    last_g = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    m0_addr = 32'h9000_0000; m0_w_rb = 1'b0; m0_acc = 2'd2; m0_wdata = '0;
    txn(1, 0, 0, 0, 0);
    txn(1, 1, 0, 0, 1);
    txn(1, 1, 1, 0, 1);
    txn(1, 1, 2, 0, 1);
    txn(1, 0, 0, 0, 1);
    txn(0, 1, 0, 3, 1);
    m0_addr = 32'h7000_0000;
    txn(1, 0, 0, 2, 0);
    txn(1, 0, TO, 1, 1);
    txn(0, 1, TO, 0, 1);
    txn(1, 0, 2, 2, 1);
    m0_req = 1'b1; m0_addr = $urandom;
    step();
    chk("rw_issue", s_req, 1);
    step();
    chk("rw_wait", {s_req, busy}, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0; m0_req = 1'b0; s_resp = 1'b1; s_rdata = 32'hdead_beef;
    chk("rw_rst", {m0_resp, m1_resp, tmo, busy}, 0);
    step();
    s_resp = 1'b0;
    chk("rw_ignored", {m0_resp, m1_resp, tmo, busy, s_req}, 0);
    last_g = 1'b1;
    txn(1, 1, 0, 0, 1);
    for (int i = 0; i < 60; i++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!(r0 || r1 || m0_req || m1_req)) r0 = 1'b1;
      txn(r0, r1, int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 3)), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
